regfile_2r1w_clr: RTL
=====================

Name: regfile_2r1w_clr

Overview:
- Parametrised successor to the single-port register file: one synchronous write port, two independent registered read ports, and hardwired constant addresses.
- Adds a write-first bypass and a sequenced clear engine that zeroes the writable registers one per cycle.
- Sits between instruction decode (selects) and the ALU (operands A/B), with writeback driving the write port.

Parameters:
- SELECT_WIDTH, 4, width of every select address; the MSB selects constant space.
- REG_WIDTH, 8, width of one register and of all data ports.
- NUM_REGS, 4, number of writable registers; legal range 1 to 2**(SELECT_WIDTH-1).

Ports:
- i_clk  input  1  clock; all logic is on the rising edge.
- i_rst  input  1  synchronous active-high reset.
- i_wrEn  input  1  write enable.
- i_wrSel  input  SELECT_WIDTH  write address.
- i_wrData  input  REG_WIDTH  write data.
- i_rdSelA  input  SELECT_WIDTH  read address, port A.
- i_rdSelB  input  SELECT_WIDTH  read address, port B.
- o_rdDataA  output  REG_WIDTH  registered read data, port A.
- o_rdDataB  output  REG_WIDTH  registered read data, port B.
- i_clrReq  input  1  one-cycle request to start a clear sweep.
- o_busy  output  1  high while a clear sweep is in progress.
- o_wrDrop  output  1  one-cycle pulse: the previous cycle's write was rejected.

Behaviour:
Reset:
- i_rst high at a clock edge: all writable registers = 0, o_rdDataA = o_rdDataB = 0, o_busy = 0, o_wrDrop = 0, FSM = IDLE, sweep index = 0.
- Reset overrides every other input, including mid-sweep. A sweep interrupted by reset is abandoned, and the registers are zero anyway.

Address map (applies to both read ports; write legality is under Writes):
- MSB = 0, address < NUM_REGS: writable register.
- MSB = 0, address >= NUM_REGS: reads 0.
- MSB = 1, low bits = 0: constant 0.
- MSB = 1, low bits = 1: constant 1 (zero-extended).
- MSB = 1, low bits = 2: constant all-ones.
- MSB = 1, any other low bits: constant 0.

Reads:
- Both ports sample their selects every cycle; data appears on the output one cycle later (latency 1).
- Reads are never suppressed by a write, unlike the previous block.
- Bypass: if a write is accepted in the same cycle and its address equals a read select, that port outputs i_wrData (write-first). This applies to A and B independently.

Writes:
- A write is accepted only when i_wrEn = 1, the FSM is IDLE, the address MSB = 0, and the address < NUM_REGS.
- Any other write with i_wrEn = 1 is rejected: register contents are unchanged, and o_wrDrop = 1 on the next cycle. The MSB = 0, address >= NUM_REGS case is part of this rule.
- o_wrDrop returns to 0 when there is no rejected write.

Clear FSM:
- IDLE: when i_clrReq = 1, go to CLEAR with index = 0. o_busy goes high on the next cycle.
  - A write in that same i_clrReq cycle is accepted normally and the sweep clears it later.
- CLEAR: each cycle, register[index] = 0 and index increments.
  - After clearing index NUM_REGS-1, return to IDLE. o_busy is high for exactly NUM_REGS cycles.
  - i_clrReq is ignored while in CLEAR.
  - All writes are rejected while in CLEAR, and the bypass is disabled.
  - Reads return current contents, so already-swept registers read 0.
- Index width is clog2(NUM_REGS), with a minimum of 1. It must not wrap beyond NUM_REGS-1.

Width rules:
- Constant 1 is 1 zero-extended to REG_WIDTH; all-ones is REG_WIDTH ones.
- No arithmetic on data.

Test Plan:
1. Reset, then read A = 0x0 and B = 0x9 -> after 1 cycle A = 0x00, B = 0x01. Read B = 0xA -> 0xFF. Read 0xB -> 0x00.
2. Write 0x5A to reg 2, next cycle read A = 2, B = 2 -> both 0x5A one cycle later, and o_wrDrop stays 0.
3. Write 0x3C to reg 1 with i_rdSelA = 1 in the same cycle -> o_rdDataA = 0x3C on the next cycle (bypass). o_rdDataB with i_rdSelB = 3 reads the old reg 3.
4. Write 0x77 to address 0x8, then to address 0x5 (NUM_REGS = 4) -> o_wrDrop pulses after each. Reading 0x8 gives 0x00 and reading 0x5 gives 0x00.
5. Load regs 0–3 with 0x11, 0x22, 0x33, 0x44, then pulse i_clrReq -> o_busy high for exactly 4 cycles. A write to reg 0 during the sweep gives o_wrDrop = 1. A second i_clrReq during the sweep is ignored. Afterwards all regs read 0x00.
6. Start a sweep, then assert i_rst on the 2nd busy cycle -> next cycle o_busy = 0, outputs = 0, and all regs read 0x00. A write to reg 3 right after is accepted.

Source files
------------

// File: rtl/regfile_2r1w_clr.sv
// Two-read / one-write register file with hardwired constant addresses,
// a write-first bypass and a sequenced clear sweep over the writable registers.
module regfile_2r1w_clr #(
  parameter int SELECT_WIDTH = 4,
  parameter int REG_WIDTH    = 8,
  parameter int NUM_REGS     = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_wrEn,
  input  logic [SELECT_WIDTH-1:0] i_wrSel,
  input  logic [REG_WIDTH-1:0]    i_wrData,
  input  logic [SELECT_WIDTH-1:0] i_rdSelA,
  input  logic [SELECT_WIDTH-1:0] i_rdSelB,
  output logic [REG_WIDTH-1:0]    o_rdDataA,
  output logic [REG_WIDTH-1:0]    o_rdDataB,
  input  logic                    i_clrReq,
  output logic                    o_busy,
  output logic                    o_wrDrop
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int LOW_W = SELECT_WIDTH - 1;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t               state, state_next;
  logic [IDX_W-1:0]     idx, idx_next;
  logic [REG_WIDTH-1:0] regs [NUM_REGS];
  logic                 wr_accept;
  logic [REG_WIDTH-1:0] rd_next_a, rd_next_b;

  assign wr_accept = i_wrEn && (state == IDLE) && !i_wrSel[SELECT_WIDTH-1] &&
                     (int'(i_wrSel[LOW_W-1:0]) < NUM_REGS);

  // Write-first: an accepted write to the selected address wins over storage.
  function automatic logic [REG_WIDTH-1:0] read_sel(input logic [SELECT_WIDTH-1:0] sel);
    logic [REG_WIDTH-1:0] val;
    val = '0;
    if (wr_accept && (i_wrSel == sel)) begin
      val = i_wrData;
    end else if (sel[SELECT_WIDTH-1]) begin
      case (sel[LOW_W-1:0])
        LOW_W'(1): val = REG_WIDTH'(1);
        LOW_W'(2): val = '1;
        default:   val = '0;
      endcase
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (sel[LOW_W-1:0] == LOW_W'(i)) val = regs[i];
      end
    end
    return val;
  endfunction

  always_comb begin
    rd_next_a = read_sel(i_rdSelA);
    rd_next_b = read_sel(i_rdSelB);
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    idx_next   = idx;
    case (state)
      IDLE: begin
        if (i_clrReq) begin
          state_next = CLEAR;
          idx_next   = '0;
        end
      end
      CLEAR: begin
        if (idx == IDX_W'(NUM_REGS - 1)) begin
          state_next = IDLE;
          idx_next   = '0;
        end else begin
          idx_next = idx + IDX_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        idx_next   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      idx       <= '0;
      o_rdDataA <= '0;
      o_rdDataB <= '0;
      o_wrDrop  <= 1'b0;
    end else begin
      state     <= state_next;
      idx       <= idx_next;
      o_rdDataA <= rd_next_a;
      o_rdDataB <= rd_next_b;
      o_wrDrop  <= i_wrEn && !wr_accept;
    end
  end

  // NOTE: the storage array is reset because reset must leave every register reading zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if ((state == CLEAR) && (idx == IDX_W'(i))) begin
          regs[i] <= '0;
        end else if (wr_accept && (i_wrSel[LOW_W-1:0] == LOW_W'(i))) begin
          regs[i] <= i_wrData;
        end
      end
    end
  end

  assign o_busy = (state == CLEAR);

endmodule
